uart_frame_tx: RTL and testbench
================================

UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 SHALL provide parameter NUM_WORDS, default 6, meaning the count of 16-bit sensor words per frame (accel X/Y/Z, gyro X/Y/Z).
REQ-002 SHALL provide parameter HDR0, default 8'h55, meaning the first header byte.
REQ-003 SHALL provide parameter HDR1, default 8'hAA, meaning the second header byte.
REQ-004 SHALL have port clk_in, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-006 SHALL have port sample_data, input, 16*NUM_WORDS bits: word k occupies bits [16k+15:16k].
REQ-007 SHALL have port sample_valid, input, 1 bit: the upstream sample is valid.
REQ-008 SHALL have port sample_ready, output, 1 bit: the block accepts a sample.
REQ-009 SHALL have port m_axis_tdata, output, 8 bits: frame byte to the UART transmitter.
REQ-010 SHALL have port m_axis_tvalid, output, 1 bit: frame byte valid.
REQ-011 SHALL have port m_axis_tready, input, 1 bit: the UART transmitter accepts the byte.
REQ-012 SHALL have port frame_busy, output, 1 bit: a frame is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, HDR0, HDR1, DATA and CSUM.
REQ-014 SHALL assert sample_ready only in IDLE; a sample is accepted when sample_valid and sample_ready are both high, and the accepted sample_data is latched in full.
REQ-015 SHALL move from IDLE to HDR0 on acceptance, so that m_axis_tvalid=1 with tdata=HDR0 in the cycle after acceptance (1-cycle latency).
REQ-016 SHALL advance HDR0->HDR1->DATA->CSUM->IDLE, each transition occurring only on a handshake (m_axis_tvalid and m_axis_tready both high).
REQ-017 SHALL, in DATA, emit 2*NUM_WORDS bytes in order word 0..NUM_WORDS-1, high byte first, using a byte index counter that resets to 0 on entry to DATA.
REQ-018 SHALL make the CSUM byte equal to the 8-bit modulo-256 sum of the 2*NUM_WORDS data bytes only; header bytes are excluded and carries are discarded.
REQ-019 SHALL hold m_axis_tvalid high continuously from HDR0 through CSUM, and keep m_axis_tdata stable while tvalid=1 and tready=0.
REQ-020 SHALL tolerate m_axis_tready held low indefinitely, stalling with no byte loss and no duplication.
REQ-021 SHALL drive m_axis_tvalid low in IDLE.
REQ-022 SHALL return to IDLE in the cycle after the CSUM handshake and raise sample_ready there, giving a minimum frame period of 2*NUM_WORDS+4 cycles.
REQ-023 SHALL ignore changes on sample_data and sample_valid while not in IDLE; the latched copy is used for the whole frame.
REQ-024 SHALL drive frame_busy = (state != IDLE).
REQ-025 SHALL drive m_axis_tdata to 8'h00 whenever m_axis_tvalid=0.

Reset
REQ-026 SHALL, on rst, immediately set state=IDLE, sample_ready=0, m_axis_tvalid=0, m_axis_tdata=8'h00, frame_busy=0, byte index=0, checksum=0 and the sample latch to 0.
REQ-027 SHALL assert sample_ready in the first clock after rst deasserts.
REQ-028 SHALL, on rst asserted mid-frame, abandon the frame with no partial-frame resumption; the next frame starts again with HDR0.

Structure
REQ-029 SHALL place the FSM state encoding, the default header constants and the frame-length function (2*NUM_WORDS+3) in the shared uart package.
REQ-030 SHALL have no sub-module; the checksum accumulator is updated inline on each DATA handshake.

Verification
REQ-031 SHALL cover the single-frame case: words 0x0102,0x0304,0x0506,0x0708,0x090A,0x0B0C with tready=1 -> bytes 55 AA 01 02 03 04 05 06 07 08 09 0A 0B 0C 4E over 15 consecutive cycles, then IDLE.
REQ-032 SHALL cover checksum wrap: all words 0xFFFF -> 12 data bytes FF, CSUM=0xF4.
REQ-033 SHALL cover backpressure: random tready at 30% duty -> the same 15-byte sequence as REQ-031, tdata stable under every stall, no extra handshakes.
REQ-034 SHALL cover back-to-back frames: sample_valid held high with a new value on each acceptance -> two complete frames, sample_ready pulsed once per frame, period 16 cycles at tready=1.
REQ-035 SHALL cover reset mid-frame: rst pulsed during DATA byte 5 -> tvalid=0 in the same cycle, then a new sample yields a fresh frame beginning with 55.
REQ-036 SHALL cover sample change during a frame: sample_data altered after acceptance -> the frame carries only the originally accepted values.

Source files
------------

// File: rtl/uart_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_tx_pkg
// Brief    : Shared state encoding, header defaults and frame-length helper
//            for the sensor-frame UART byte serialiser.
// Revision : 1.0 - initial release
// ============================================================================
package uart_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    localparam logic [7:0] C_HDR0_DEFAULT = 8'h55;
    localparam logic [7:0] C_HDR1_DEFAULT = 8'hAA;

    // Total bytes on the wire: two header bytes, two per word, one checksum.
    function automatic int frame_len(input int num_words);
        return 2 * num_words + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_tx
// Brief    : Latches a multi-word sensor sample and streams it as a framed
//            byte sequence (header, data high-byte first, 8-bit checksum).
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int         NUM_WORDS = 6,
    parameter logic [7:0] HDR0      = C_HDR0_DEFAULT,
    parameter logic [7:0] HDR1      = C_HDR1_DEFAULT
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [16*NUM_WORDS-1:0]  sample_data,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     frame_busy
);

    localparam int DATA_BYTES = frame_len(NUM_WORDS) - 3;
    localparam int IDX_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_BYTES - 1);

    // Even index selects the high byte of word i/2, odd index the low byte.
    function automatic logic [7:0] data_byte(input logic [16*NUM_WORDS-1:0] d,
                                             input logic [IDX_W-1:0]        i);
        int sh;
        sh = 16 * (int'(i) / 2) + (i[0] ? 0 : 8);
        return d[sh +: 8];
    endfunction

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [7:0]                csum_q, csum_d;
    logic [16*NUM_WORDS-1:0]   data_q, data_d;
    logic                      ready_q, ready_d;
    logic                      tvalid_q, tvalid_d;
    logic [7:0]                tdata_q, tdata_d;
    logic                      busy_q, busy_d;
    logic                      w_hs;

    assign w_hs = tvalid_q && m_axis_tready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (ready_q && sample_valid) begin
                    data_d  = sample_data;
                    idx_d   = '0;
                    csum_d  = '0;
                    state_d = ST_HDR0;
                end
            end
            ST_HDR0: if (w_hs) state_d = ST_HDR1;
            ST_HDR1: begin
                if (w_hs) begin
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    csum_d = csum_q + data_byte(data_q, idx_q);
                    if (idx_q == C_LAST_IDX) begin
                        state_d = ST_CSUM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_CSUM: if (w_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are precomputed from the next state so they register cleanly.
        ready_d  = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
        tvalid_d = (state_d != ST_IDLE);
        case (state_d)
            ST_HDR0: tdata_d = HDR0;
            ST_HDR1: tdata_d = HDR1;
            ST_DATA: tdata_d = data_byte(data_d, idx_d);
            ST_CSUM: tdata_d = csum_d;
            default: tdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            csum_q   <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= 8'h00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            busy_q   <= busy_d;
        end
    end

    assign sample_ready  = ready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign frame_busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_tx
// Brief    : Directed self-checking bench for uart_frame_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_tx;

    localparam logic [95:0]  C_D1 = 96'h0B0C_090A_0708_0506_0304_0102;
    localparam logic [119:0] C_F1 = 120'h55AA_0102_0304_0506_0708_090A_0B0C_4E;
    localparam logic [95:0]  C_D2 = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [119:0] C_F2 = 120'h55AA_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_F4;
    localparam logic [95:0]  C_D3 = 96'h6000_5000_4000_3000_2000_1000;
    localparam logic [119:0] C_F3 = 120'h55AA_1000_2000_3000_4000_5000_6000_50;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [95:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        frame_busy;

    int n_checks = 0;
    int n_pass   = 0;

    uart_frame_tx #(.NUM_WORDS(6), .HDR0(8'h55), .HDR1(8'hAA)) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_busy    (frame_busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] frame_byte(input logic [119:0] f, input int k);
        return 8'(f >> (8 * (14 - k)));
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
        check({tag, "_ready"},  32'(sample_ready),  32'd1);
        check({tag, "_busy"},   32'(frame_busy),    32'd0);
    endtask

    // Present a sample for exactly one accepting edge; returns on the next negedge.
    task automatic start(input logic [95:0] d);
        int t = 0;
        @(negedge clk_in);
        while (!sample_ready && t < 50) begin
            @(negedge clk_in);
            t++;
        end
        if (!sample_ready) check("ready_timeout", 32'(sample_ready), 32'd1);
        sample_data  = d;
        sample_valid = 1'b1;
        @(negedge clk_in);
        sample_valid = 1'b0;
    endtask

    // Collect one frame with tready high duty% of cycles, checking order and hold.
    task automatic collect(input logic [119:0] f, input int duty);
        int         k       = 0;
        int         cyc     = 0;
        logic       stalled = 1'b0;
        logic [7:0] prev    = 8'h00;
        while (k < 15 && cyc < 200) begin
            if (stalled) check("stall_hold", 32'(m_axis_tdata), 32'(prev));
            check("tvalid_hold", 32'(m_axis_tvalid), 32'd1);
            m_axis_tready = ($urandom_range(0, 99) < duty);
            if (m_axis_tvalid && m_axis_tready) begin
                check($sformatf("byte%0d", k), 32'(m_axis_tdata), 32'(frame_byte(f, k)));
                k++;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            prev    = m_axis_tdata;
            @(negedge clk_in);
            cyc++;
        end
        check("frame_len", 32'(k), 32'd15);
        m_axis_tready = 1'b1;
        check_idle("post_frame");
    endtask

    initial begin
        int acc [4];
        int nacc;
        int nb;

        rst           = 1'b1;
        sample_data   = '0;
        sample_valid  = 1'b0;
        m_axis_tready = 1'b1;
        #1;
        check("rst_ready",  32'(sample_ready),  32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata",  32'(m_axis_tdata),  32'd0);
        check("rst_busy",   32'(frame_busy),    32'd0);
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        check_idle("after_rst");

        // Single frame at full throughput.
        start(C_D1);
        collect(C_F1, 100);

        // Checksum wraps modulo 256.
        start(C_D2);
        collect(C_F2, 100);

        // Random backpressure.
        start(C_D1);
        collect(C_F1, 30);

        // Input data changes after acceptance must not leak into the frame.
        start(C_D1);
        sample_data = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;
        collect(C_F1, 100);

        // Back-to-back frames with sample_valid held high.
        m_axis_tready = 1'b1;
        @(negedge clk_in);
        sample_data  = C_D1;
        sample_valid = 1'b1;
        nacc = 0;
        nb   = 0;
        for (int c = 0; c < 32; c++) begin
            if (sample_ready) begin
                if (nacc < 4) acc[nacc] = c;
                nacc++;
            end
            if (m_axis_tvalid) begin
                if (nb < 15)
                    check($sformatf("b2b_a%0d", nb), 32'(m_axis_tdata), 32'(frame_byte(C_F1, nb)));
                else if (nb < 30)
                    check($sformatf("b2b_b%0d", nb - 15), 32'(m_axis_tdata), 32'(frame_byte(C_F3, nb - 15)));
                nb++;
            end
            @(negedge clk_in);
            if (nacc == 1) sample_data = C_D3;
            else if (nacc >= 2) sample_data = 96'h0;
        end
        sample_valid = 1'b0;
        check("b2b_accepts", 32'(nacc), 32'd2);
        check("b2b_period",  32'(acc[1] - acc[0]), 32'd16);
        check("b2b_bytes",   32'(nb), 32'd30);
        @(negedge clk_in);
        check_idle("b2b_end");

        // Reset during data byte 5, then a fresh frame.
        start(C_D1);
        m_axis_tready = 1'b1;
        repeat (7) @(negedge clk_in);
        check("pre_rst_byte", 32'(m_axis_tdata), 32'h06);
        rst = 1'b1;
        #1;
        check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("midrst_tdata",  32'(m_axis_tdata),  32'd0);
        check("midrst_busy",   32'(frame_busy),    32'd0);
        check("midrst_ready",  32'(sample_ready),  32'd0);
        @(negedge clk_in);
        rst = 1'b0;
        start(C_D1);
        collect(C_F1, 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
